// File: rtl/pe_cmd_defines.sv
// rtl/pe_cmd_defines.sv - shared register map, trigger value and sequencer state encodings
package pe_cmd_defines;

  // Wrapper slave register offsets
  localparam logic [2:0] REG_ADDR = 3'd0;
  localparam logic [2:0] REG_D1   = 3'd1;
  localparam logic [2:0] REG_D2   = 3'd2;
  localparam logic [2:0] REG_D3   = 3'd3;
  localparam logic [2:0] REG_D4   = 3'd4;
  localparam logic [2:0] REG_TRIG = 3'd5;

  // Value written to the trigger register to commit the staged instruction
  localparam logic [31:0] TRIG_VALUE = 32'h1;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_BEAT  = 2'd1,
    ST_GAP   = 2'd2,
    ST_SHRST = 2'd3
  } seqState_e;

endpackage

// File: rtl/pe_instr_load_sequencer.sv
// rtl/pe_instr_load_sequencer.sv - serialises 128-bit instructions into wrapper bus writes
module pe_instr_load_sequencer
  import pe_cmd_defines::*;
#(
  parameter int DataWidth      = 32,
  parameter int AddrWidth      = 5,
  parameter int RstPulseCycles = 2
) (
  input  logic                   iClk,
  input  logic                   iReset_n,
  input  logic                   iLoad_valid,
  output logic                   oLoad_ready,
  input  logic [AddrWidth-1:0]   iLoad_addr,
  input  logic [4*DataWidth-1:0] iLoad_instr,
  input  logic                   iLoad_last,
  output logic                   oChipSelect_n,
  output logic                   oWrite_n,
  output logic                   oRead_n,
  output logic [31:0]            oAddress,
  output logic [DataWidth-1:0]   oData,
  output logic                   oShader_rst_n,
  output logic                   oBusy,
  output logic                   oInstr_done,
  output logic                   oProg_done,
  output logic [AddrWidth:0]     oInstr_count
);

  localparam int RstCntW = (RstPulseCycles > 1) ? $clog2(RstPulseCycles) : 1;
  localparam logic [AddrWidth:0] MaxCount = {1'b1, {AddrWidth{1'b0}}};

  seqState_e state, nextState;

  logic [2:0]             beatIdx;
  logic [2:0]             nextIdx;
  logic [RstCntW-1:0]     rstCnt;
  logic [4*DataWidth-1:0] instrQ;
  logic                   lastQ;
  logic                   progDoneQ;
  logic                   handshake;
  logic                   instrCommit;
  logic [DataWidth-1:0]   beatWord;

  assign handshake   = (state == ST_IDLE) && iLoad_valid;
  assign instrCommit = (state == ST_GAP) && (beatIdx == REG_TRIG);
  assign nextIdx     = handshake ? REG_ADDR : beatIdx + 3'd1;

  // State register
  always_ff @(posedge iClk) begin
    if (!iReset_n) begin
      state <= ST_IDLE;
    end else begin
      state <= nextState;
    end
  end

  // Next-state: BEAT/GAP alternate six times, then optional shader-reset hold
  always_comb begin
    nextState = state;
    unique case (state)
      ST_IDLE:  if (iLoad_valid) nextState = ST_BEAT;
      ST_BEAT:  nextState = ST_GAP;
      ST_GAP: begin
        if (beatIdx == REG_TRIG) begin
          nextState = lastQ ? ST_SHRST : ST_IDLE;
        end else begin
          nextState = ST_BEAT;
        end
      end
      ST_SHRST: if (rstCnt == '0) nextState = ST_IDLE;
      default:  nextState = ST_IDLE;
    endcase
  end

  // Word for the beat being entered; index 0 only occurs at the handshake,
  // so the address comes straight from the input while it is being latched
  always_comb begin
    beatWord = '0;
    unique case (nextIdx)
      REG_ADDR: beatWord = DataWidth'(iLoad_addr);
      REG_D1:   beatWord = instrQ[4*DataWidth-1:3*DataWidth];
      REG_D2:   beatWord = instrQ[3*DataWidth-1:2*DataWidth];
      REG_D3:   beatWord = instrQ[2*DataWidth-1:DataWidth];
      REG_D4:   beatWord = instrQ[DataWidth-1:0];
      REG_TRIG: beatWord = DataWidth'(TRIG_VALUE);
      default:  beatWord = '0;
    endcase
  end

  // Datapath: latch instruction, step beat index, register bus address/data, count commits
  always_ff @(posedge iClk) begin
    if (!iReset_n) begin
      beatIdx      <= REG_ADDR;
      rstCnt       <= '0;
      instrQ       <= '0;
      lastQ        <= 1'b0;
      progDoneQ    <= 1'b0;
      oAddress     <= '0;
      oData        <= '0;
      oInstr_count <= '0;
    end else begin
      progDoneQ <= (state == ST_SHRST) && (nextState == ST_IDLE);
      if (handshake) begin
        instrQ  <= iLoad_instr;
        lastQ   <= iLoad_last;
        beatIdx <= REG_ADDR;
      end else if ((state == ST_GAP) && (beatIdx != REG_TRIG)) begin
        beatIdx <= beatIdx + 3'd1;
      end
      if (nextState == ST_BEAT) begin
        oAddress <= 32'(nextIdx);
        oData    <= beatWord;
      end
      if (nextState == ST_SHRST && state == ST_GAP) begin
        rstCnt <= RstCntW'(RstPulseCycles - 1);
      end else if ((state == ST_SHRST) && (rstCnt != '0)) begin
        rstCnt <= rstCnt - 1'b1;
      end
      if ((state == ST_SHRST) && (nextState == ST_IDLE)) begin
        oInstr_count <= '0;
      end else if (instrCommit && (oInstr_count != MaxCount)) begin
        oInstr_count <= oInstr_count + 1'b1;
      end
    end
  end

  // Moore outputs decoded from the current state
  always_comb begin
    oLoad_ready   = (state == ST_IDLE);
    oBusy         = (state != ST_IDLE);
    oChipSelect_n = (state != ST_BEAT);
    oWrite_n      = (state != ST_BEAT);
    oShader_rst_n = (state != ST_SHRST);
    oInstr_done   = instrCommit;
    oProg_done    = progDoneQ;
  end

  assign oRead_n = 1'b1;

endmodule
